// File: rtl/pri_icache_pkg.sv
// Shared types and helpers for the icache fetch prefetcher.
package pri_icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BRANCH_WAIT
  } fetch_state_e;

  // Byte distance between consecutive instruction words.
  function automatic int unsigned ADDR_STEP(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pri_icache_fetch_fifo.sv
// Instruction buffer: holds returned words with their fetch address; flush empties it at once.
module pri_icache_fetch_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic [ADDR_WIDTH-1:0]        push_addr,
  input  logic                         pop,
  output logic                         valid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [ADDR_WIDTH-1:0]        raddr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        addr_mem[wr_ptr] <= push_addr;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign rdata = data_mem[rd_ptr];
  assign raddr = addr_mem[rd_ptr];

endmodule

// File: rtl/pri_icache_fetch_prefetcher.sv
// Sequential instruction prefetcher feeding the core from the private icache fetch port,
// with credit-limited issue, branch redirect and discard of stale in-flight responses.
module pri_icache_fetch_prefetcher
  import pri_icache_pkg::*;
#(
  parameter int unsigned FETCH_ADDR_WIDTH = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_i,
  input  logic                        branch_i,
  input  logic [FETCH_ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [FETCH_DATA_WIDTH-1:0] rdata_o,
  output logic [FETCH_ADDR_WIDTH-1:0] addr_o,
  output logic                        busy_o,
  output logic                        fetch_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                        fetch_gnt_i,
  input  logic                        fetch_rvalid_i,
  input  logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i
);

  localparam int unsigned           CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [FETCH_ADDR_WIDTH-1:0] STEP = FETCH_ADDR_WIDTH'(ADDR_STEP(FETCH_DATA_WIDTH));
  localparam logic [FETCH_ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - FETCH_ADDR_WIDTH'(1));

  fetch_state_e                state, state_next;
  logic [FETCH_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FETCH_ADDR_WIDTH-1:0] target_q, target_d;
  logic [FETCH_ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
  logic [FETCH_ADDR_WIDTH-1:0] branch_target;
  logic [CW-1:0]               outstanding_q, outstanding_d;
  logic [CW-1:0]               discard_q, discard_d;
  logic [CW-1:0]               fifo_count;
  logic                        pending_q;
  logic                        pending_now;
  logic                        credit;
  logic                        gnt;
  logic                        rvalid;
  logic                        push;

  assign branch_target = branch_addr_i & ALIGN_MASK;
  assign credit = ((CW+1)'(outstanding_q) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);
  // Responses with nothing outstanding are leftovers from before a reset.
  assign rvalid      = fetch_rvalid_i && (outstanding_q != '0);
  assign gnt         = fetch_req_o && fetch_gnt_i;
  assign pending_now = fetch_req_o && !fetch_gnt_i;
  assign push        = rvalid && !branch_i && (discard_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (branch_i && req_i) state_next = RUN;
      RUN: begin
        if (branch_i)                     state_next = pending_now ? BRANCH_WAIT : RUN;
        else if (!req_i && !pending_now)  state_next = IDLE;
      end
      BRANCH_WAIT: if (fetch_gnt_i) state_next = RUN;
      default:     state_next = IDLE;
    endcase
  end

  // A raised request is held until granted, even if req_i or credit later drop.
  always_comb begin
    case (state)
      RUN:         fetch_req_o = pending_q || (req_i && credit);
      BRANCH_WAIT: fetch_req_o = 1'b1;
      default:     fetch_req_o = 1'b0;
    endcase
    fetch_addr_o = addr_q;
    busy_o       = (outstanding_q != '0) || fetch_req_o;
  end

  always_comb begin
    addr_d      = addr_q;
    target_d    = target_q;
    resp_addr_d = resp_addr_q;
    case ({gnt, rvalid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    discard_d = discard_q;
    if (branch_i) begin
      if (pending_now) target_d = branch_target;
      else             addr_d   = branch_target;
      resp_addr_d = branch_target;
      discard_d   = outstanding_d;
    end else begin
      if (gnt) addr_d = (state == BRANCH_WAIT) ? target_q : addr_q + STEP;
      if (push) resp_addr_d = resp_addr_q + STEP;
      if (rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if ((state == BRANCH_WAIT) && gnt) discard_d = discard_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      target_q      <= '0;
      resp_addr_q   <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      pending_q     <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      target_q      <= target_d;
      resp_addr_q   <= resp_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pending_q     <= pending_now;
    end
  end

  pri_icache_fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (FETCH_DATA_WIDTH),
    .ADDR_WIDTH (FETCH_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_i),
    .push      (push),
    .push_data (fetch_rdata_i),
    .push_addr (resp_addr_q),
    .pop       (ready_i),
    .valid     (valid_o),
    .rdata     (rdata_o),
    .raddr     (addr_o),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pri_icache_fetch_prefetcher.sv
// Directed per-cycle vector table plus an address-wrap sequence for the fetch prefetcher.
module tb_pri_icache_fetch_prefetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, ready_i;
  logic [31:0] branch_addr_i;
  logic        valid_o, busy_o, fetch_req_o;
  logic [31:0] rdata_o, addr_o, fetch_addr_o;
  logic        fetch_gnt_i, fetch_rvalid_i;
  logic [31:0] fetch_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_row = 0;

  always #5 clk = ~clk;

  pri_icache_fetch_prefetcher #(
    .FETCH_ADDR_WIDTH (32),
    .FETCH_DATA_WIDTH (32),
    .FIFO_DEPTH       (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .busy_o         (busy_o),
    .fetch_req_o    (fetch_req_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_gnt_i    (fetch_gnt_i),
    .fetch_rvalid_i (fetch_rvalid_i),
    .fetch_rdata_i  (fetch_rdata_i)
  );

  typedef struct {
    logic        rst, req, br, rdy, gnt, rv;
    logic [31:0] ba, rd;
    logic        ev, eb, efr, cd;
    logic [31:0] erd, ea, efa;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int rst, input int req, input int br, input logic [31:0] ba,
                             input int rdy, input int gnt, input int rv, input logic [31:0] rd,
                             input int ev, input logic [31:0] erd, input logic [31:0] ea,
                             input int eb, input int efr, input logic [31:0] efa);
    vec_t r;
    r.rst = 1'(rst); r.req = 1'(req); r.br = 1'(br); r.ba = ba;
    r.rdy = 1'(rdy); r.gnt = 1'(gnt); r.rv = 1'(rv); r.rd = rd;
    r.ev = 1'(ev); r.erd = erd; r.ea = ea; r.eb = 1'(eb); r.efr = 1'(efr); r.efa = efa;
    r.cd = r.ev | ~r.rst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, cur_row, act, exp);
    end
  endtask

  task automatic add_reset();
    vecs.push_back(v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0; ready_i = 1'b0;
    fetch_gnt_i = 1'b0; fetch_rvalid_i = 1'b0; fetch_rdata_i = '0;

    // Streaming from 0x1000, core always ready
    add_reset();
    vecs.push_back(v(1,1,1,'h1000, 1,1,0,0,     0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1000));
    vecs.push_back(v(1,1,0,0,      1,1,1,'hA0,  0,0,0,          1,1,'h1004));
    vecs.push_back(v(1,1,0,0,      1,1,1,'hA1,  1,'hA0,'h1000,  1,0,'h1008));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     1,'hA1,'h1004,  1,1,'h1008));
    vecs.push_back(v(1,1,0,0,      1,1,1,'hA2,  0,0,0,          1,1,'h100C));
    vecs.push_back(v(1,0,0,0,      1,0,1,'hA3,  1,'hA2,'h1008,  1,0,'h1010));
    vecs.push_back(v(1,0,0,0,      1,0,0,0,     1,'hA3,'h100C,  0,0,'h1010));
    vecs.push_back(v(1,0,0,0,      1,0,0,0,     0,0,0,          0,0,'h1010));
    // Core stalled: credit stops issue at two; then branch flushes a non-empty buffer
    add_reset();
    vecs.push_back(v(1,1,1,'h1000, 0,1,0,0,     0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      0,1,0,0,     0,0,0,          1,1,'h1000));
    vecs.push_back(v(1,1,0,0,      0,1,1,'hB0,  0,0,0,          1,1,'h1004));
    vecs.push_back(v(1,1,0,0,      0,1,1,'hB1,  1,'hB0,'h1000,  1,0,'h1008));
    vecs.push_back(v(1,1,0,0,      0,1,0,0,     1,'hB0,'h1000,  0,0,'h1008));
    vecs.push_back(v(1,1,0,0,      0,1,0,0,     1,'hB0,'h1000,  0,0,'h1008));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     1,'hB0,'h1000,  0,0,'h1008));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     1,'hB1,'h1004,  1,1,'h1008));
    vecs.push_back(v(1,1,0,0,      1,0,1,'hB2,  0,0,0,          1,1,'h100C));
    vecs.push_back(v(1,1,1,'h5000, 0,0,0,0,     1,'hB2,'h1008,  1,1,'h100C));
    vecs.push_back(v(1,1,0,0,      0,1,0,0,     0,0,0,          1,1,'h100C));
    vecs.push_back(v(1,0,0,0,      0,0,1,'hBF,  0,0,0,          1,0,'h5000));
    vecs.push_back(v(1,0,0,0,      0,0,0,0,     0,0,0,          0,0,'h5000));
    // Branch to 0x2002 while 0x1008 waits for grant
    add_reset();
    vecs.push_back(v(1,1,1,'h1000, 1,1,0,0,     0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1000));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1004));
    vecs.push_back(v(1,1,0,0,      1,0,1,'hC0,  0,0,0,          1,0,'h1008));
    vecs.push_back(v(1,1,0,0,      1,0,1,'hC1,  1,'hC0,'h1000,  1,0,'h1008));
    vecs.push_back(v(1,1,0,0,      1,0,0,0,     1,'hC1,'h1004,  1,1,'h1008));
    vecs.push_back(v(1,1,1,'h2002, 1,0,0,0,     0,0,0,          1,1,'h1008));
    vecs.push_back(v(1,1,0,0,      1,0,0,0,     0,0,0,          1,1,'h1008));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1008));
    vecs.push_back(v(1,1,0,0,      1,0,1,'hCF,  0,0,0,          1,1,'h2000));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h2000));
    vecs.push_back(v(1,0,0,0,      1,0,1,'hC2,  0,0,0,          1,0,'h2004));
    vecs.push_back(v(1,0,0,0,      1,0,0,0,     1,'hC2,'h2000,  0,0,'h2004));
    vecs.push_back(v(1,0,0,0,      1,0,0,0,     0,0,0,          0,0,'h2004));
    // Two outstanding, then branch to 0x3000
    add_reset();
    vecs.push_back(v(1,1,1,'h1000, 1,1,0,0,     0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1000));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1004));
    vecs.push_back(v(1,1,1,'h3000, 1,1,0,0,     0,0,0,          1,0,'h1008));
    vecs.push_back(v(1,1,0,0,      1,1,1,'hDD,  0,0,0,          1,0,'h3000));
    vecs.push_back(v(1,1,0,0,      1,1,1,'hDE,  0,0,0,          1,1,'h3000));
    vecs.push_back(v(1,0,0,0,      1,0,1,'hD0,  0,0,0,          1,0,'h3004));
    vecs.push_back(v(1,0,0,0,      1,0,0,0,     1,'hD0,'h3000,  0,0,'h3004));
    vecs.push_back(v(1,0,0,0,      1,0,0,0,     0,0,0,          0,0,'h3004));
    // Branch coincident with rvalid and gnt
    add_reset();
    vecs.push_back(v(1,1,1,'h1000, 1,1,0,0,     0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1000));
    vecs.push_back(v(1,1,1,'h4000, 1,1,1,'hE0,  0,0,0,          1,1,'h1004));
    vecs.push_back(v(1,1,0,0,      1,0,1,'hEF,  0,0,0,          1,1,'h4000));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h4000));
    vecs.push_back(v(1,0,0,0,      1,0,1,'hE1,  0,0,0,          1,0,'h4004));
    vecs.push_back(v(1,0,0,0,      1,0,0,0,     1,'hE1,'h4000,  0,0,'h4004));
    // Reset with two outstanding; late responses must be ignored
    add_reset();
    vecs.push_back(v(1,1,1,'h1000, 1,1,0,0,     0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1000));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          1,1,'h1004));
    vecs.push_back(v(0,1,0,0,      1,1,0,0,     0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,1,'hF0,  0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,1,'hF1,  0,0,0,          0,0,0));
    vecs.push_back(v(1,1,0,0,      1,1,0,0,     0,0,0,          0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n          = vecs[i].rst;
      req_i          = vecs[i].req;
      branch_i       = vecs[i].br;
      branch_addr_i  = vecs[i].ba;
      ready_i        = vecs[i].rdy;
      fetch_gnt_i    = vecs[i].gnt;
      fetch_rvalid_i = vecs[i].rv;
      fetch_rdata_i  = vecs[i].rd;
      #1;
      cur_row = i;
      chk("valid_o",      32'(valid_o),     32'(vecs[i].ev));
      chk("busy_o",       32'(busy_o),      32'(vecs[i].eb));
      chk("fetch_req_o",  32'(fetch_req_o), 32'(vecs[i].efr));
      chk("fetch_addr_o", fetch_addr_o,     vecs[i].efa);
      if (vecs[i].cd) begin
        chk("rdata_o", rdata_o, vecs[i].erd);
        chk("addr_o",  addr_o,  vecs[i].ea);
      end
    end

    // Unaligned branch near the top of the address space: fetch wraps to 0
    begin
      logic [31:0] pend_addr;
      logic        pend;
      int          grants;
      int          got;
      pend = 1'b0; pend_addr = '0; grants = 0; got = 0;
      cur_row = -1;
      @(negedge clk);
      rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; fetch_gnt_i = 1'b0; fetch_rvalid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFB;
      fetch_gnt_i = 1'b1; ready_i = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
        @(negedge clk);
        branch_i       = 1'b0;
        fetch_rvalid_i = pend;
        fetch_rdata_i  = pend_addr ^ 32'h5A5A_0000;
        req_i          = (grants < 3);
        #1;
        if (valid_o) begin
          chk("wrap addr_o",  addr_o,  32'hFFFF_FFF8 + 32'(got) * 32'd4);
          chk("wrap rdata_o", rdata_o, (32'hFFFF_FFF8 + 32'(got) * 32'd4) ^ 32'h5A5A_0000);
          got++;
        end
        if (fetch_req_o && fetch_gnt_i) begin
          chk("wrap fetch_addr_o", fetch_addr_o, 32'hFFFF_FFF8 + 32'(grants) * 32'd4);
          grants++;
          pend      = 1'b1;
          pend_addr = fetch_addr_o;
        end else begin
          pend = 1'b0;
        end
      end
      chk("wrap deliveries", 32'(got), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
